load_store_unit: RTL and testbench

- Memory-access stage between the register file and data memory.
- Takes a decoded load/store (base from rs1 read port, store data from rs2 read port, immediate offset) and computes the effective address.
- Runs a request/acknowledge transaction on the data-memory bus.
- For loads, returns the aligned, sign- or zero-extended result on a one-cycle write-back interface that the register file consumes.

---
 rtl/rv32i_pkg.sv | 16 +
 rtl/lsu_align.sv | 89 ++++++++
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I memory-access definitions.
// Holds the funct3 width/sign codes, the load/store unit FSM state type
// and the operation kind latched by the load/store unit.
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

    typedef enum logic {LOAD, STORE} lsu_op_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   i_op         load or store
//   i_funct3     RV32I width/sign code
//   i_ea_lo      effective address bits [1:0]
//   i_store_data rs2 value
//   i_rdata      word read from data memory
//   o_wdata      lane-replicated store data (zero for loads)
//   o_wstrb      byte-lane write strobes (zero for loads)
//   o_load_data  extracted, extended load result
//   o_legal      funct3 legal for the op and address naturally aligned
module lsu_align
    import rv32i_pkg::*;
(
    input  lsu_op_t     i_op,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_ea_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_load_data,
    output logic        o_legal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_ea_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_ea_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_legal = 1'b0;
        case (i_funct3)
            F3_B:    o_legal = 1'b1;
            F3_H:    o_legal = ~i_ea_lo[0];
            F3_W:    o_legal = (i_ea_lo == 2'b00);
            F3_BU:   o_legal = (i_op == LOAD);
            F3_HU:   o_legal = (i_op == LOAD) && !i_ea_lo[0];
            default: o_legal = 1'b0;
        endcase
    end

    always_comb begin
        o_wdata = '0;
        o_wstrb = '0;
        if (i_op == STORE) begin
            case (i_funct3)
                F3_B: begin
                    o_wdata = {4{i_store_data[7:0]}};
                    o_wstrb = 4'b0001 << i_ea_lo;
                end
                F3_H: begin
                    o_wdata = {2{i_store_data[15:0]}};
                    o_wstrb = 4'b0011 << i_ea_lo;
                end
                F3_W: begin
                    o_wdata = i_store_data;
                    o_wstrb = 4'b1111;
                end
                default: begin
                    o_wdata = '0;
                    o_wstrb = '0;
                end
            endcase
        end
    end

    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_load_data = i_rdata;
            F3_BU:   o_load_data = {24'b0, w_byte};
            F3_HU:   o_load_data = {16'b0, w_half};
            default: o_load_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: memory-access stage between the register file and data
// memory. Accepts one decoded load/store at a time, computes base+offset,
// runs a req/ack bus transaction with timeout, and returns loads on a
// one-cycle write-back strobe.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready, is_load, is_store, funct3, base, offset,
//     store_data, rd                              decoded operation in
//   mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, mem_ack, mem_rdata
//                                                  data-memory bus
//   wb_valid, wb_rd, wb_data                       load write-back
//   done, misalign_err, bus_err                    retirement pulses
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned XLEN           = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            is_load,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            done,
    output logic            misalign_err,
    output logic            bus_err
);

    lsu_state_t r_state;
    lsu_state_t w_next;
    lsu_op_t    r_op;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_ea;
    logic [XLEN-1:0] r_sd;
    logic [4:0]      r_rd;
    logic [7:0]      r_cnt;
    logic            r_mis;
    logic            r_berr;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;

    logic [XLEN-1:0] w_ea;
    lsu_op_t         w_in_op;
    logic            w_accept;
    logic            w_timeout;
    lsu_op_t         w_sel_op;
    logic [2:0]      w_sel_f3;
    logic [1:0]      w_sel_ea_lo;
    logic [XLEN-1:0] w_wdata;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_load_data;
    logic            w_legal;

    assign w_ea      = base + offset;
    assign w_in_op   = is_load ? LOAD : STORE;
    assign w_accept  = (r_state == IDLE) && req_valid && (is_load || is_store);
    assign w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

    // One aligner serves both jobs: in IDLE it checks legality of the
    // incoming op, afterwards it drives lanes/extraction from the latch.
    assign w_sel_op    = (r_state == IDLE) ? w_in_op    : r_op;
    assign w_sel_f3    = (r_state == IDLE) ? funct3     : r_funct3;
    assign w_sel_ea_lo = (r_state == IDLE) ? w_ea[1:0]  : r_ea[1:0];

    lsu_align u_align (
        .i_op         (w_sel_op),
        .i_funct3     (w_sel_f3),
        .i_ea_lo      (w_sel_ea_lo),
        .i_store_data (r_sd),
        .i_rdata      (mem_rdata),
        .o_wdata      (w_wdata),
        .o_wstrb      (w_wstrb),
        .o_load_data  (w_load_data),
        .o_legal      (w_legal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        req_ready    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wstrb    = '0;
        done         = 1'b0;
        misalign_err = 1'b0;
        bus_err      = 1'b0;
        wb_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_next = w_legal ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                mem_req   = 1'b1;
                mem_we    = (r_op == STORE);
                mem_addr  = {r_ea[XLEN-1:2], 2'b00};
                mem_wdata = w_wdata;
                mem_wstrb = w_wstrb;
                if (mem_ack || w_timeout) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                done         = 1'b1;
                misalign_err = r_mis;
                bus_err      = r_berr;
                wb_valid     = !r_mis && !r_berr && (r_op == LOAD) && (r_rd != 5'd0);
                w_next       = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // wb_rd/wb_data are captured on the ack edge so they are new exactly
    // in RESP and otherwise keep the last written-back value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op      <= LOAD;
            r_funct3  <= '0;
            r_ea      <= '0;
            r_sd      <= '0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_mis     <= 1'b0;
            r_berr    <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op     <= w_in_op;
                        r_funct3 <= funct3;
                        r_ea     <= w_ea;
                        r_sd     <= store_data;
                        r_rd     <= rd;
                        r_cnt    <= '0;
                        r_mis    <= !w_legal;
                        r_berr   <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        if ((r_op == LOAD) && (r_rd != 5'd0)) begin
                            r_wb_rd   <= r_rd;
                            r_wb_data <= w_load_data;
                        end
                    end else if (w_timeout) begin
                        r_berr <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wb_rd   = r_wb_rd;
    assign wb_data = r_wb_data;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] base, offset, store_data;
    logic [4:0]  rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        done, misalign_err, bus_err;

    load_store_unit #(.TIMEOUT_CYCLES(TMO), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .is_load(is_load), .is_store(is_store), .funct3(funct3),
        .base(base), .offset(offset), .store_data(store_data), .rd(rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(done), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected outputs for the current cycle
    bit          chk_en = 1'b0;
    logic        e_ready, e_req, e_we, e_wbv, e_done, e_mis, e_berr;
    logic [31:0] e_addr, e_wdata, e_wbdata;
    logic [3:0]  e_wstrb;
    logic [4:0]  e_wbrd;
    logic [4:0]  m_last_rd   = '0;
    logic [31:0] m_last_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Access size in bytes, 0 when funct3 is not legal for the op
    function automatic int m_size(input bit ld, input logic [2:0] f3);
        case (f3)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b010:  return 4;
            3'b100:  return ld ? 1 : 0;
            3'b101:  return ld ? 2 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_legal(input bit ld, input logic [2:0] f3, input logic [31:0] ea);
        int sz = m_size(ld, f3);
        if (sz == 0) return 1'b0;
        return (ea % sz) == 0;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] ea);
        int sz = m_size(1'b0, f3);
        int mask = (1 << sz) - 1;
        return 4'(mask << (ea % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int sz = m_size(1'b0, f3);
        if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] ea, input logic [31:0] rdata);
        int sz = m_size(1'b1, f3);
        logic [31:0] mask, val;
        if (sz == 4) return rdata;
        mask = (sz == 1) ? 32'hFF : 32'hFFFF;
        val  = (rdata >> (8 * (ea % 4))) & mask;
        if (f3 < 3'b100 && (val > (mask >> 1))) val = val | ~mask;
        return val;
    endfunction

    task automatic set_idle();
        e_ready = 1'b1; e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
        e_wstrb = '0; e_done = 1'b0; e_mis = 1'b0; e_berr = 1'b0; e_wbv = 1'b0;
        e_wbrd = m_last_rd; e_wbdata = m_last_data;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready",    32'(req_ready),    32'(e_ready));
            chk("mem_req",      32'(mem_req),      32'(e_req));
            chk("mem_we",       32'(mem_we),       32'(e_we));
            chk("mem_addr",     mem_addr,          e_addr);
            chk("mem_wstrb",    32'(mem_wstrb),    32'(e_wstrb));
            if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            chk("done",         32'(done),         32'(e_done));
            chk("misalign_err", 32'(misalign_err), 32'(e_mis));
            chk("bus_err",      32'(bus_err),      32'(e_berr));
            chk("wb_valid",     32'(wb_valid),     32'(e_wbv));
            chk("wb_rd",        32'(wb_rd),        32'(e_wbrd));
            chk("wb_data",      wb_data,           e_wbdata);
        end
    end

    // ack_at: cycle (1-based after accept) in which mem_ack is driven; 0 = never
    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] b, input logic [31:0] off,
                          input logic [31:0] sd, input logic [4:0] r,
                          input int ack_at, input logic [31:0] rdv,
                          input bit pin, input logic [31:0] pin_val);
        logic [31:0] ea;
        bit is_ld, acked;
        ea    = b + off;
        is_ld = ld;
        acked = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        base = b; offset = off; store_data = sd; rd = r;
        set_idle();
        @(posedge clk); #1;
        req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        base = $urandom; offset = $urandom; store_data = $urandom; rd = 5'($urandom);
        if (!m_legal(is_ld, f3, ea)) begin
            set_idle();
            e_ready = 1'b0; e_done = 1'b1; e_mis = 1'b1;
            @(posedge clk); #1;
            set_idle();
            return;
        end
        for (int c = 1; c <= int'(TMO); c++) begin
            set_idle();
            e_ready = 1'b0; e_req = 1'b1; e_we = !is_ld;
            e_addr  = {ea[31:2], 2'b00};
            e_wstrb = is_ld ? 4'b0000 : m_wstrb(f3, ea);
            e_wdata = m_wdata(f3, sd);
            mem_ack   = (c == ack_at);
            mem_rdata = (c == ack_at) ? rdv : $urandom;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = $urandom;
            if (c == ack_at) begin
                acked = 1'b1;
                break;
            end
        end
        if (acked && is_ld && r != 5'd0) begin
            m_last_rd   = r;
            m_last_data = m_load(f3, ea, rdv);
        end
        set_idle();
        e_ready = 1'b0; e_done = 1'b1;
        e_berr  = !acked;
        e_wbv   = acked && is_ld && (r != 5'd0);
        if (pin) begin
            @(negedge clk); #1;
            chk("pin_wb_data", wb_data, pin_val);
        end
        @(posedge clk); #1;
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = '0; base = '0; offset = '0; store_data = '0; rd = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        set_idle();
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_req",   32'(mem_req),   32'd0);
        chk("rst_wb_valid",  32'(wb_valid),  32'd0);
        chk("rst_wb_data",   wb_data,        32'd0);

        // Pin the model to hand-computed values
        chk("m_lb",   m_load(3'b000, 32'h203, 32'h80FF_0102), 32'hFFFF_FF80);
        chk("m_lbu",  m_load(3'b100, 32'h203, 32'h80FF_0102), 32'h0000_0080);
        chk("m_sh_d", m_wdata(3'b001, 32'h1234_ABCD),         32'hABCD_ABCD);
        chk("m_sh_s", 32'(m_wstrb(3'b001, 32'h302)),          32'h0000_000C);
        chk("m_lw_a", 32'(m_legal(1'b1, 3'b010, 32'h101)),    32'd0);

        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;

        //      ld st  f3      base          offset        sd            rd  ack rdata         pin
        run_op(1, 0, 3'b010, 32'h100,      32'h4,        32'h0,        5,  3, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
        run_op(1, 0, 3'b000, 32'h200,      32'h3,        32'h0,        6,  1, 32'h80FF_0102, 1, 32'hFFFF_FF80);
        run_op(1, 0, 3'b100, 32'h200,      32'h3,        32'h0,        7,  1, 32'h80FF_0102, 1, 32'h0000_0080);
        run_op(0, 1, 3'b001, 32'h300,      32'h2,        32'h1234_ABCD, 3, 2, 32'h0,        0, 32'h0);
        run_op(1, 0, 3'b010, 32'h100,      32'h1,        32'h0,        5,  1, 32'h0,         0, 32'h0);
        run_op(1, 0, 3'b010, 32'h400,      32'h0,        32'h0,        8,  0, 32'h0,         0, 32'h0);
        run_op(1, 0, 3'b001, 32'h200,      32'h2,        32'h0,        0,  1, 32'h1111_2222, 0, 32'h0);
        run_op(1, 0, 3'b001, 32'h200,      32'h2,        32'h0,        9,  2, 32'h8001_1234, 1, 32'hFFFF_8001);
        run_op(1, 0, 3'b101, 32'h200,      32'h0,        32'h0,        10, 1, 32'h1234_F00D, 1, 32'h0000_F00D);
        run_op(0, 1, 3'b000, 32'h10,       32'hFFFF_FFF3, 32'hAA,      1,  1, 32'h0,         0, 32'h0);
        run_op(0, 1, 3'b010, 32'h8,        32'h0,        32'hCAFE_F00D, 1, 4, 32'h0,        0, 32'h0);
        run_op(0, 1, 3'b100, 32'h8,        32'h0,        32'h55,       1,  1, 32'h0,         0, 32'h0);
        run_op(1, 1, 3'b010, 32'hFFFF_FFFC, 32'h8,       32'h77,       11, 1, 32'h0BAD_CAFE, 1, 32'h0BAD_CAFE);
        run_op(1, 0, 3'b011, 32'h0,        32'h0,        32'h0,        12, 1, 32'h0,         0, 32'h0);
        run_op(1, 0, 3'b001, 32'h200,      32'h1,        32'h0,        12, 1, 32'h0,         0, 32'h0);

        // req_valid with neither op bit, plus a stray ack: both ignored
        @(posedge clk); #1;
        req_valid = 1'b1; mem_ack = 1'b1;
        set_idle();
        @(posedge clk); #1;
        req_valid = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;

        // Reset asserted while the bus cycle is outstanding
        req_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010;
        base = 32'h500; offset = 32'h0; rd = 5'd13;
        set_idle();
        @(posedge clk); #1;
        req_valid = 1'b0; is_load = 1'b0;
        e_ready = 1'b0; e_req = 1'b1; e_addr = 32'h500;
        @(posedge clk); #1;
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        chk("arst_mem_req",   32'(mem_req),   32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd1);
        chk("arst_done",      32'(done),      32'd0);
        m_last_rd = '0; m_last_data = '0;
        set_idle();
        @(posedge clk); #1;
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1 mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
